// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer.
//
// Allocates one entry per issued instruction in program order and returns
// its tag. Entries complete through two writeback ports. Up to COMMIT_W
// completed entries retire per cycle, oldest first. Operand lookup reads an
// entry's result, bypassing a writeback that lands on it in the same cycle.
// flush discards every entry in one cycle.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    discard all entries (beats issue/wb/commit)
//   issue_valid/ready        allocation handshake (ready = !full)
//   issue_dest/regwrite      destination register and RF write enable
//   issue_tag                tag being allocated this cycle (tail pointer)
//   wbN_valid/tag/value      writeback ports 0 and 1 (wb1 wins on a tie)
//   lk_X_tag/ready/value     operand lookup ports a and b
//   commit_valid/we          per-slot retire and RF write strobes
//   commit_addr/data/tag     per-slot packed fields, slot 0 in the LSBs
//   count, empty, full       occupancy

module rob_param #(
    parameter int DEPTH    = 16,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int COMMIT_W = 2,
    parameter int TAG_W    = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [REG_W-1:0]             issue_dest,
    input  logic                         issue_regwrite,
    output logic [TAG_W-1:0]             issue_tag,
    input  logic                         wb0_valid,
    input  logic [TAG_W-1:0]             wb0_tag,
    input  logic [DATA_W-1:0]            wb0_value,
    input  logic                         wb1_valid,
    input  logic [TAG_W-1:0]             wb1_tag,
    input  logic [DATA_W-1:0]            wb1_value,
    input  logic [TAG_W-1:0]             lk_a_tag,
    input  logic [TAG_W-1:0]             lk_b_tag,
    output logic                         lk_a_ready,
    output logic                         lk_b_ready,
    output logic [DATA_W-1:0]            lk_a_value,
    output logic [DATA_W-1:0]            lk_b_value,
    output logic [COMMIT_W-1:0]          commit_valid,
    output logic [COMMIT_W-1:0]          commit_we,
    output logic [COMMIT_W*REG_W-1:0]    commit_addr,
    output logic [COMMIT_W*DATA_W-1:0]   commit_data,
    output logic [COMMIT_W*TAG_W-1:0]    commit_tag,
    output logic [TAG_W:0]               count,
    output logic                         empty,
    output logic                         full
);

    logic [DEPTH-1:0]  e_valid;
    logic [DEPTH-1:0]  e_ready;
    logic [DEPTH-1:0]  e_rw;
    logic [REG_W-1:0]  e_dest  [DEPTH];
    logic [DATA_W-1:0] e_value [DEPTH];

    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    count_q;

    logic              issue_fire;
    logic              wb0_hit;
    logic              wb1_hit;
    logic              fire_chain;
    logic [TAG_W:0]    retire_n;
    logic [TAG_W-1:0]  slot_idx [COMMIT_W];

    assign count       = count_q;
    assign full        = (count_q == (TAG_W+1)'(DEPTH));
    assign empty       = (count_q == '0);
    assign issue_ready = !full;
    assign issue_tag   = tail;
    assign issue_fire  = issue_valid && !full;
    assign wb0_hit     = wb0_valid && e_valid[wb0_tag];
    assign wb1_hit     = wb1_valid && e_valid[wb1_tag];

    // Slot i may only retire when every older slot retires too, so the
    // fire condition is chained from slot 0 upward. Flush kills the chain.
    always_comb begin
        fire_chain   = !flush;
        retire_n     = '0;
        commit_valid = '0;
        commit_we    = '0;
        commit_addr  = '0;
        commit_data  = '0;
        commit_tag   = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            slot_idx[i] = head + TAG_W'(i);
            fire_chain  = fire_chain && e_valid[slot_idx[i]] && e_ready[slot_idx[i]];
            commit_valid[i] = fire_chain;
            commit_we[i]    = fire_chain && e_rw[slot_idx[i]];
            commit_addr[i*REG_W +: REG_W]   = e_dest[slot_idx[i]];
            commit_data[i*DATA_W +: DATA_W] = e_value[slot_idx[i]];
            commit_tag[i*TAG_W +: TAG_W]    = slot_idx[i];
            retire_n = retire_n + (TAG_W+1)'(fire_chain);
        end
    end

    // Returns {ready, value}; a same-cycle writeback to a live entry is
    // forwarded, wb1 taking precedence to match the write order below.
    function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] t);
        logic [DATA_W:0] r;
        r = '0;
        if (e_valid[t]) begin
            if (wb1_valid && wb1_tag == t)
                r = {1'b1, wb1_value};
            else if (wb0_valid && wb0_tag == t)
                r = {1'b1, wb0_value};
            else
                r = {e_ready[t], e_value[t]};
        end
        return r;
    endfunction

    assign {lk_a_ready, lk_a_value} = lookup(lk_a_tag);
    assign {lk_b_ready, lk_b_value} = lookup(lk_b_tag);

    // Within one edge: writebacks first, then retire clears, then issue.
    // The issued entry is always invalid beforehand, so it can never collide
    // with a writeback (ignored) or a retiring entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid <= '0;
            e_ready <= '0;
            e_rw    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_dest[i]  <= '0;
                e_value[i] <= '0;
            end
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            e_valid <= '0;
            e_ready <= '0;
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (wb0_hit) begin
                e_ready[wb0_tag] <= 1'b1;
                e_value[wb0_tag] <= wb0_value;
            end
            if (wb1_hit) begin
                e_ready[wb1_tag] <= 1'b1;
                e_value[wb1_tag] <= wb1_value;
            end
            for (int i = 0; i < COMMIT_W; i++) begin
                if (commit_valid[i]) begin
                    e_valid[slot_idx[i]] <= 1'b0;
                    e_ready[slot_idx[i]] <= 1'b0;
                end
            end
            if (issue_fire) begin
                e_valid[tail] <= 1'b1;
                e_ready[tail] <= 1'b0;
                e_rw[tail]    <= issue_regwrite;
                e_dest[tail]  <= issue_dest;
                e_value[tail] <= '0;
                tail          <= tail + 1'b1;
            end
            head    <= head + retire_n[TAG_W-1:0];
            count_q <= count_q + (TAG_W+1)'(issue_fire) - retire_n;
        end
    end

endmodule

// File: tb/tb_rob_param.sv
module tb_rob_param;

    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int CW    = 2;
    localparam int TW    = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             issue_valid;
    logic             issue_ready;
    logic [RW-1:0]    issue_dest;
    logic             issue_regwrite;
    logic [TW-1:0]    issue_tag;
    logic             wb0_valid, wb1_valid;
    logic [TW-1:0]    wb0_tag, wb1_tag;
    logic [DW-1:0]    wb0_value, wb1_value;
    logic [TW-1:0]    lk_a_tag, lk_b_tag;
    logic             lk_a_ready, lk_b_ready;
    logic [DW-1:0]    lk_a_value, lk_b_value;
    logic [CW-1:0]    commit_valid, commit_we;
    logic [CW*RW-1:0] commit_addr;
    logic [CW*DW-1:0] commit_data;
    logic [CW*TW-1:0] commit_tag;
    logic [TW:0]      count;
    logic             empty, full;

    rob_param #(.DEPTH(DEPTH), .DATA_W(DW), .REG_W(RW), .COMMIT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_dest(issue_dest), .issue_regwrite(issue_regwrite),
        .issue_tag(issue_tag),
        .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_value(wb0_value),
        .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_value(wb1_value),
        .lk_a_tag(lk_a_tag), .lk_b_tag(lk_b_tag),
        .lk_a_ready(lk_a_ready), .lk_b_ready(lk_b_ready),
        .lk_a_value(lk_a_value), .lk_b_value(lk_b_value),
        .commit_valid(commit_valid), .commit_we(commit_we),
        .commit_addr(commit_addr), .commit_data(commit_data),
        .commit_tag(commit_tag),
        .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the live instructions as a program-ordered queue.
    typedef struct {
        int         tag;
        logic [4:0] dest;
        logic       rw;
        logic       rdy;
        logic [31:0] val;
    } ent_t;

    ent_t mq[$];
    int   m_tail  = 0;
    bit   run_chk = 0;

    function automatic int mfind(input int t);
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].tag == t) return i;
        return -1;
    endfunction

    function automatic int m_ncommit();
        int n;
        n = 0;
        if (!flush && mq.size() > 0 && mq[0].rdy) begin
            n = 1;
            if (mq.size() > 1 && mq[1].rdy) n = 2;
        end
        return n;
    endfunction

    task automatic check_lk(input string nm, input int t, input logic act_r, input logic [31:0] act_v);
        int   k;
        logic er;
        logic [31:0] ev;
        k  = mfind(t);
        er = 1'b0;
        ev = '0;
        if (k >= 0) begin
            if (wb1_valid && int'(wb1_tag) == t) begin er = 1'b1; ev = wb1_value; end
            else if (wb0_valid && int'(wb0_tag) == t) begin er = 1'b1; ev = wb0_value; end
            else begin er = mq[k].rdy; ev = mq[k].val; end
        end
        chk({nm, "_ready"}, act_r, er);
        if (er || k < 0) chk({nm, "_value"}, act_v, ev);
    endtask

    // Compare process: outputs are checked every cycle, mid-phase.
    always @(negedge clk) begin : cmp
        int n;
        logic [1:0] exp_we;
        #2;
        if (run_chk) begin
            if (rst) begin
                mq.delete();
                m_tail = 0;
            end
            chk("count", count, mq.size());
            chk("empty", empty, mq.size() == 0);
            chk("full", full, mq.size() == DEPTH);
            chk("issue_ready", issue_ready, mq.size() < DEPTH);
            chk("issue_tag", issue_tag, m_tail);
            n = rst ? 0 : m_ncommit();
            chk("commit_valid", commit_valid, (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00);
            exp_we = 2'b00;
            for (int s = 0; s < n; s++) begin
                exp_we[s] = mq[s].rw;
                chk("commit_addr", commit_addr[s*RW +: RW], mq[s].dest);
                chk("commit_data", commit_data[s*DW +: DW], mq[s].val);
                chk("commit_tag", commit_tag[s*TW +: TW], mq[s].tag);
            end
            chk("commit_we", commit_we, exp_we);
            check_lk("lk_a", int'(lk_a_tag), lk_a_ready, lk_a_value);
            check_lk("lk_b", int'(lk_b_tag), lk_b_ready, lk_b_value);
        end
    end

    // Model state update at the active edge.
    always @(posedge clk) begin : mupd
        int n, k;
        bit can_issue;
        if (rst) begin
            mq.delete();
            m_tail = 0;
        end else if (flush) begin
            mq.delete();
            m_tail = 0;
        end else begin
            n = m_ncommit();
            can_issue = mq.size() < DEPTH;
            if (wb0_valid) begin
                k = mfind(int'(wb0_tag));
                if (k >= 0) begin mq[k].rdy = 1'b1; mq[k].val = wb0_value; end
            end
            if (wb1_valid) begin
                k = mfind(int'(wb1_tag));
                if (k >= 0) begin mq[k].rdy = 1'b1; mq[k].val = wb1_value; end
            end
            repeat (n) void'(mq.pop_front());
            if (issue_valid && can_issue) begin
                mq.push_back('{m_tail, issue_dest, issue_regwrite, 1'b0, 32'd0});
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    end

    task automatic clr();
        issue_valid = 1'b0;
        wb0_valid   = 1'b0;
        wb1_valid   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic issue(input int dest, input bit rw);
        issue_valid    = 1'b1;
        issue_dest     = RW'(dest);
        issue_regwrite = rw;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        issue_dest = '0; issue_regwrite = 1'b0;
        wb0_tag = '0; wb1_tag = '0; wb0_value = '0; wb1_value = '0;
        lk_a_tag = '0; lk_b_tag = '0;
        repeat (2) @(negedge clk);
        run_chk = 1;
        #3;
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_issue_tag", issue_tag, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_lk_ready", lk_a_ready, 0);
        @(negedge clk); rst = 1'b0;

        // Fill to capacity with no writebacks.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); clr(); issue(i + 1, 1);
            #3 chk("fill_tag", issue_tag, i);
        end
        @(negedge clk); clr(); issue(17, 1);
        #3;
        chk("fill_full", full, 1);
        chk("fill_ready", issue_ready, 0);
        chk("fill_count", count, 16);
        @(negedge clk); clr();
        #3 chk("fill_17th_ignored", count, 16);
        @(negedge clk); clr(); flush = 1'b1;
        @(negedge clk); clr();
        #3 chk("flush_empty", empty, 1);

        // Dual commit with an in-order stall on the head.
        @(negedge clk); clr(); issue(3, 1);
        #3 chk("dual_tag0", issue_tag, 0);
        @(negedge clk); clr(); issue(4, 1);
        @(negedge clk); clr(); wb0_valid = 1; wb0_tag = 1; wb0_value = 32'hAA;
        repeat (2) begin
            @(negedge clk); clr();
            #3 chk("stall_commit", commit_valid, 0);
        end
        @(negedge clk); clr(); wb1_valid = 1; wb1_tag = 0; wb1_value = 32'h55;
        #3 chk("stall_wb_cycle", commit_valid, 0);
        @(negedge clk); clr();
        #3;
        chk("dual_valid", commit_valid, 2'b11);
        chk("dual_we", commit_we, 2'b11);
        chk("dual_addr", commit_addr, 10'h083);
        chk("dual_data", commit_data, 64'h000000AA_00000055);
        chk("dual_tag", commit_tag, 8'h10);

        // Store-like entry: retires without an RF write.
        @(negedge clk); clr(); issue(7, 0);
        #3 chk("store_tag", issue_tag, 2);
        @(negedge clk); clr(); wb0_valid = 1; wb0_tag = 2; wb0_value = 32'h77;
        @(negedge clk); clr();
        #3;
        chk("store_valid", commit_valid, 2'b01);
        chk("store_we", commit_we, 2'b00);
        chk("store_data", commit_data[31:0], 32'h77);

        // Flush masks a commit that would otherwise fire.
        @(negedge clk); clr(); issue(8, 1);
        @(negedge clk); clr(); wb0_valid = 1; wb0_tag = 3; wb0_value = 32'h1;
        @(negedge clk); clr(); flush = 1'b1;
        #3 chk("flush_masks_commit", commit_valid, 0);

        // Bypass lookup, then flush with five entries live.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); clr(); issue(i + 1, 1);
            if (i == 0) #3 chk("after_flush_tag", issue_tag, 0);
        end
        @(negedge clk); clr();
        lk_a_tag = 2; lk_b_tag = 6;
        wb0_valid = 1; wb0_tag = 2; wb0_value = 32'h1234;
        #3;
        chk("bypass_ready", lk_a_ready, 1);
        chk("bypass_value", lk_a_value, 32'h1234);
        chk("lk_invalid_ready", lk_b_ready, 0);
        chk("lk_invalid_value", lk_b_value, 0);
        @(negedge clk); clr(); flush = 1'b1;
        #3 chk("pre_flush_count", count, 5);
        @(negedge clk); clr(); issue(9, 1);
        #3;
        chk("post_flush_count", count, 0);
        chk("post_flush_empty", empty, 1);
        chk("post_flush_tag", issue_tag, 0);

        // Steady issue + writeback + commit every cycle, wrapping the pointers.
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk); clr(); issue(i % 32, 1);
            wb0_valid = 1; wb0_tag = TW'((i - 1) % 16); wb0_value = 32'h1000 + i - 1;
            #3;
            chk("wrap_tag", issue_tag, i % 16);
            if (i >= 2) chk("wrap_count", count, 2);
        end

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); clr();
            rst = ($urandom_range(0, 599) == 0);
            flush = ($urandom_range(0, 79) == 0);
            if (((i / 400) % 2) == 0) issue_valid = ($urandom_range(0, 3) != 0);
            else issue_valid = ($urandom_range(0, 3) == 0);
            issue_dest = RW'($urandom);
            issue_regwrite = $urandom_range(0, 1);
            wb0_valid = ($urandom_range(0, 2) == 0);
            wb1_valid = ($urandom_range(0, 2) == 0);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                wb0_tag = TW'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                wb0_tag = TW'($urandom);
            if ($urandom_range(0, 4) == 0)
                wb1_tag = wb0_tag;
            else if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                wb1_tag = TW'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                wb1_tag = TW'($urandom);
            wb0_value = $urandom;
            wb1_value = $urandom;
            lk_a_tag = TW'($urandom);
            lk_b_tag = TW'($urandom);
        end
        @(negedge clk); clr(); rst = 1'b0;
        #3;
        run_chk = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
